hack_gpio_bank: RTL and testbench
=================================

Name: hack_gpio_bank

Overview:
Parametrised memory-mapped GPIO bank for the Hack SoC. It replaces the single write-only GPIO word with NUM_PORTS ports of WORD_WIDTH bits, each with per-bit direction, synchronised inputs, sticky rising-edge capture and a combined interrupt. It sits on the Hack data bus (addressM/outM/writeM, qualified by the hack clock strobe) and feeds the inM read mux.

Parameters:
WORD_WIDTH, 16, bits per port and bus data width
ADDRESS_WIDTH, 15, Hack data address width
NUM_PORTS, 2, number of ports; legal range 1..8
BASE_ADDRESS, 'h6001, address of port 0 register 0
SYNC_STAGES, 2, input synchroniser depth; legal range 2..3

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
bus_strobe  input  1  one-cycle qualifier: hack_clk_strobe && hack_clk; writes commit only when high
address  input  ADDRESS_WIDTH  Hack addressM
write_enable  input  1  Hack writeM
data_in  input  WORD_WIDTH  Hack outM
data_out  output  WORD_WIDTH  read data for the inM mux
hit  output  1  address falls inside the bank's register window
gpio_in  input  NUM_PORTS*WORD_WIDTH  pad inputs, asynchronous, port p at bits [p*WORD_WIDTH +: WORD_WIDTH]
gpio_out  output  NUM_PORTS*WORD_WIDTH  pad output values
gpio_oe  output  NUM_PORTS*WORD_WIDTH  pad output enables, 1 = drive
irq  output  1  interrupt, high while any EDGE bit is set

Behaviour:
- Register map, offset = address - BASE_ADDRESS, port p = offset>>2, reg = offset[1:0]:
  - 0 OUT: read/write.
  - 1 DIR: read/write, 1 = output.
  - 2 IN: read-only, synchronised pad value.
  - 3 EDGE: read; write-1-to-clear.
- hit = (address >= BASE_ADDRESS) && (address < BASE_ADDRESS + 4*NUM_PORTS). The subtraction is done at ADDRESS_WIDTH; an address below base never hits, even after wrap-around.
- Reads: data_out is combinational from address and current register state, with zero latency. When hit=0, data_out=0.
- Writes: committed on the rising clk edge where bus_strobe && write_enable && hit. Writes with bus_strobe low are ignored. Writes to IN are ignored.
- Outputs: gpio_out = OUT and gpio_oe = DIR, both registered, so they change on the clk edge of the write.
- Synchroniser: a SYNC_STAGES-deep flop chain per bit. IN reflects a pad change SYNC_STAGES clk edges after it.
- Edge detect:
  - Keeps a one-cycle-delayed copy of the synchronised value.
  - A bit whose synchronised value goes 0→1 while its DIR=0 sets its EDGE bit on the next edge.
  - Output-direction bits never set EDGE.
  - IN reads the pad regardless of DIR.
- Simultaneous clear and new edge on the same bit in the same cycle: set wins, bit stays 1.
- irq = OR of all EDGE bits, registered. It asserts one clk after the EDGE bit sets and deasserts one clk after the last bit clears.
- Changing DIR from 1 to 0 does not retroactively set EDGE. Only transitions observed after the change count.
- Reset (reset_n low, asynchronous):
  - Values: OUT, DIR, EDGE, synchroniser chain and delayed copy = 0; gpio_out = 0; gpio_oe = 0 (all pins inputs); irq = 0.
  - Release: after reset_n releases, no spurious edge is flagged for pads already high. On the first cycle after release, the delayed copy loads the synchronised value without edge detection.
- Reset mid-write: the write is lost and the register reads 0.
- Out-of-range NUM_PORTS or SYNC_STAGES: elaboration error via a generate-time check.

Test Plan:
- Reset: hold reset_n=0 with gpio_in all 1s, release, wait 5 clks -> EDGE reads 0, irq=0, gpio_oe=0, IN reads 'hFFFF.
- Write OUT: strobe write 'h00FF to 'h6002 (DIR port 0), then 'hA5A5 to 'h6001 -> gpio_out[15:0]='hA5A5, gpio_oe[15:0]='h00FF one clk later; read 'h6001 returns 'hA5A5.
- Strobe qualification: same write with bus_strobe=0 -> register unchanged (0); out-of-range write to 'h6009 with NUM_PORTS=2 -> hit=0, no register changes, data_out=0.
- Synchroniser latency: gpio_in[16] 0→1 (port 1 bit 0, DIR=0) -> IN at 'h6007 reads 'h0001 after exactly 2 clks; EDGE at 'h6008 reads 'h0001 one clk later; irq high the clk after that.
- Edge clear: write 'h0001 to 'h6008 -> EDGE reads 0 and irq drops one clk later. Repeat with a new rising edge on the same bit in the clear cycle -> EDGE stays 'h0001 and irq stays 1.
- Output bits are masked: set DIR bit 3 of port 0 = 1, toggle gpio_in[3] 0→1 -> IN bit 3 = 1, EDGE bit 3 = 0, irq = 0.

Source files
------------

// File: rtl/hack_gpio_bank.sv
// hack_gpio_bank: memory-mapped GPIO bank for the Hack SoC data bus.
// NUM_PORTS ports, each with OUT/DIR/IN/EDGE registers, per-bit direction,
// synchronised pad inputs, sticky rising-edge capture and a combined irq.
module hack_gpio_bank #(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 15,
  parameter int unsigned NUM_PORTS     = 2,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = 'h6001,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             bus_strobe,
  input  logic [ADDRESS_WIDTH-1:0]         address,
  input  logic                             write_enable,
  input  logic [WORD_WIDTH-1:0]            data_in,
  output logic [WORD_WIDTH-1:0]            data_out,
  output logic                             hit,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0]  gpio_in,
  output logic [NUM_PORTS*WORD_WIDTH-1:0]  gpio_out,
  output logic [NUM_PORTS*WORD_WIDTH-1:0]  gpio_oe,
  output logic                             irq
);

  localparam int unsigned BUS_W    = NUM_PORTS * WORD_WIDTH;
  localparam int unsigned WIN_SIZE = 4 * NUM_PORTS;
  localparam int unsigned SEL_W    = ADDRESS_WIDTH - 2;
  localparam int unsigned CNT_W    = $clog2(SYNC_STAGES + 2);
  // Edge detection is armed once the chain and the delayed copy hold a real pad sample.
  localparam logic [CNT_W-1:0] ARM_CNT = CNT_W'(SYNC_STAGES + 1);

  localparam logic [1:0] REG_OUT  = 2'd0;
  localparam logic [1:0] REG_DIR  = 2'd1;
  localparam logic [1:0] REG_IN   = 2'd2;
  localparam logic [1:0] REG_EDGE = 2'd3;

  // Reject illegal configurations at elaboration.
  if ((NUM_PORTS < 1) || (NUM_PORTS > 8)) begin : g_bad_num_ports
    $error("hack_gpio_bank: NUM_PORTS must be in 1..8");
  end
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 3)) begin : g_bad_sync_stages
    $error("hack_gpio_bank: SYNC_STAGES must be in 2..3");
  end

  logic [WORD_WIDTH-1:0]    out_q  [NUM_PORTS];
  logic [WORD_WIDTH-1:0]    out_d  [NUM_PORTS];
  logic [WORD_WIDTH-1:0]    dir_q  [NUM_PORTS];
  logic [WORD_WIDTH-1:0]    dir_d  [NUM_PORTS];
  logic [WORD_WIDTH-1:0]    edge_q [NUM_PORTS];
  logic [WORD_WIDTH-1:0]    edge_d [NUM_PORTS];
  logic [BUS_W-1:0]         sync_q [SYNC_STAGES];
  logic [BUS_W-1:0]         prev_q;
  logic [CNT_W-1:0]         arm_cnt_q;
  logic [CNT_W-1:0]         arm_cnt_d;
  logic                     irq_q;
  logic                     irq_d;

  logic [ADDRESS_WIDTH-1:0] offset;
  logic [SEL_W-1:0]         port_sel;
  logic [1:0]               reg_sel;
  logic                     wr_en;
  logic                     armed;
  logic [BUS_W-1:0]         in_sync;
  logic [BUS_W-1:0]         dir_flat;
  logic [BUS_W-1:0]         rise;

  // Address decode: the offset wraps at ADDRESS_WIDTH, so the base compare guards below-base addresses.
  always_comb begin
    offset   = address - BASE_ADDRESS;
    port_sel = offset[ADDRESS_WIDTH-1:2];
    reg_sel  = offset[1:0];
    hit      = (address >= BASE_ADDRESS) && (offset < ADDRESS_WIDTH'(WIN_SIZE));
    wr_en    = bus_strobe && write_enable && hit;
  end

  // Flatten per-port registers onto the pad buses.
  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_flat
    assign gpio_out[gp*WORD_WIDTH +: WORD_WIDTH] = out_q[gp];
    assign dir_flat[gp*WORD_WIDTH +: WORD_WIDTH] = dir_q[gp];
  end

  assign gpio_oe = dir_flat;
  assign irq     = irq_q;
  assign in_sync = sync_q[SYNC_STAGES-1];
  assign armed   = (arm_cnt_q == ARM_CNT);

  // Rising edges on input-direction bits only, suppressed during the post-reset warm-up.
  always_comb begin
    rise = '0;
    if (armed) begin
      rise = in_sync & ~prev_q & ~dir_flat;
    end
  end

  // Zero-latency read mux; reads outside the window return zero.
  always_comb begin
    data_out = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (hit && (port_sel == SEL_W'(p))) begin
        case (reg_sel)
          REG_OUT:  data_out = out_q[p];
          REG_DIR:  data_out = dir_q[p];
          REG_IN:   data_out = in_sync[p*WORD_WIDTH +: WORD_WIDTH];
          default:  data_out = edge_q[p];
        endcase
      end
    end
  end

  // Register next-state: bus writes, write-1-to-clear, and edge set (set wins over clear).
  always_comb begin
    irq_d     = 1'b0;
    arm_cnt_d = arm_cnt_q;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      out_d[p]  = out_q[p];
      dir_d[p]  = dir_q[p];
      edge_d[p] = edge_q[p];
      if (wr_en && (port_sel == SEL_W'(p))) begin
        case (reg_sel)
          REG_OUT:  out_d[p]  = data_in;
          REG_DIR:  dir_d[p]  = data_in;
          REG_EDGE: edge_d[p] = edge_q[p] & ~data_in;
          default:  ;
        endcase
      end
      edge_d[p] = edge_d[p] | rise[p*WORD_WIDTH +: WORD_WIDTH];
      irq_d     = irq_d | (|edge_q[p]);
    end
    if (!armed) begin
      arm_cnt_d = arm_cnt_q + CNT_W'(1);
    end
  end

  // Bus-visible registers, warm-up counter and irq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        out_q[p]  <= '0;
        dir_q[p]  <= '0;
        edge_q[p] <= '0;
      end
      arm_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        out_q[p]  <= out_d[p];
        dir_q[p]  <= dir_d[p];
        edge_q[p] <= edge_d[p];
      end
      arm_cnt_q <= arm_cnt_d;
      irq_q     <= irq_d;
    end
  end

  // Pad synchroniser chain and one-cycle-delayed copy of its output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= in_sync;
    end
  end

endmodule

// File: tb/tb_hack_gpio_bank.sv
// Self-checking bench for hack_gpio_bank (default parameters: 2 ports x 16 bits, base 'h6001).
module tb_hack_gpio_bank;

  logic        clk;
  logic        reset_n;
  logic        bus_strobe;
  logic [14:0] address;
  logic        write_enable;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        hit;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  int n_checks;
  int n_fail;

  hack_gpio_bank dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus_strobe   (bus_strobe),
    .address      (address),
    .write_enable (write_enable),
    .data_in      (data_in),
    .data_out     (data_out),
    .hit          (hit),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .gpio_oe      (gpio_oe),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        w;
    logic [14:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
    logic        exp_hit;
    logic [31:0] exp_out;
    logic [31:0] exp_oe;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic w, input logic [14:0] a, input logic [15:0] d);
    bus_strobe   = s;
    write_enable = w;
    address      = a;
    data_in      = d;
  endtask

  task automatic check_rd(input string name, input logic [14:0] a, input logic [15:0] exp);
    drive(1'b0, 1'b0, a, 16'h0000);
    #1;
    chk(name, {16'h0, data_out}, {16'h0, exp});
  endtask

  task automatic write_cycle(input logic [14:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, a, d);
    tick();
    drive(1'b0, 1'b0, 15'h0, 16'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //           s     w     addr      data      rd        hit   out            oe
    vecs[0]  = '{1'b1, 1'b1, 15'h6002, 16'h00FF, 16'h0000, 1'b1, 32'h0000_0000, 32'h0000_00FF};
    vecs[1]  = '{1'b1, 1'b1, 15'h6001, 16'hA5A5, 16'h0000, 1'b1, 32'h0000_A5A5, 32'h0000_00FF};
    vecs[2]  = '{1'b0, 1'b0, 15'h6001, 16'h0000, 16'hA5A5, 1'b1, 32'h0000_A5A5, 32'h0000_00FF};
    vecs[3]  = '{1'b0, 1'b1, 15'h6005, 16'h1234, 16'h0000, 1'b1, 32'h0000_A5A5, 32'h0000_00FF};
    vecs[4]  = '{1'b0, 1'b0, 15'h6005, 16'h0000, 16'h0000, 1'b1, 32'h0000_A5A5, 32'h0000_00FF};
    vecs[5]  = '{1'b1, 1'b1, 15'h6009, 16'hFFFF, 16'h0000, 1'b0, 32'h0000_A5A5, 32'h0000_00FF};
    vecs[6]  = '{1'b1, 1'b1, 15'h6000, 16'hFFFF, 16'h0000, 1'b0, 32'h0000_A5A5, 32'h0000_00FF};
    vecs[7]  = '{1'b1, 1'b0, 15'h6001, 16'hFFFF, 16'hA5A5, 1'b1, 32'h0000_A5A5, 32'h0000_00FF};
    vecs[8]  = '{1'b1, 1'b1, 15'h6005, 16'h1234, 16'h0000, 1'b1, 32'h1234_A5A5, 32'h0000_00FF};
    vecs[9]  = '{1'b1, 1'b1, 15'h6003, 16'hFFFF, 16'h0000, 1'b1, 32'h1234_A5A5, 32'h0000_00FF};
    vecs[10] = '{1'b0, 1'b0, 15'h6003, 16'h0000, 16'h0000, 1'b1, 32'h1234_A5A5, 32'h0000_00FF};
    vecs[11] = '{1'b1, 1'b1, 15'h6006, 16'h00F0, 16'h0000, 1'b1, 32'h1234_A5A5, 32'h00F0_00FF};
    vecs[12] = '{1'b0, 1'b0, 15'h6006, 16'h0000, 16'h00F0, 1'b1, 32'h1234_A5A5, 32'h00F0_00FF};
    vecs[13] = '{1'b0, 1'b0, 15'h6008, 16'h0000, 16'h0000, 1'b1, 32'h1234_A5A5, 32'h00F0_00FF};
    vecs[14] = '{1'b0, 1'b0, 15'h6004, 16'h0000, 16'h0000, 1'b1, 32'h1234_A5A5, 32'h00F0_00FF};

    // Reset with all pads high; no edge may be flagged after release.
    reset_n = 1'b0;
    gpio_in = 32'hFFFF_FFFF;
    drive(1'b0, 1'b0, 15'h0, 16'h0);
    repeat (3) tick();
    chk("rst_oe", gpio_oe, 32'h0);
    chk("rst_out", gpio_out, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    repeat (5) tick();
    check_rd("rst_edge0", 15'h6004, 16'h0000);
    check_rd("rst_edge1", 15'h6008, 16'h0000);
    check_rd("rst_in0", 15'h6003, 16'hFFFF);
    check_rd("rst_in1", 15'h6007, 16'hFFFF);
    chk("rst_irq_rel", {31'h0, irq}, 32'h0);
    chk("rst_oe_rel", gpio_oe, 32'h0);
    tick();
    chk("rst_irq_late", {31'h0, irq}, 32'h0);

    // Falling pads never set EDGE.
    gpio_in = 32'h0;
    repeat (4) tick();
    check_rd("fall_edge0", 15'h6004, 16'h0000);

    // Table: bus writes/reads, strobe qualification, window boundaries.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d);
      #1;
      chk($sformatf("v%0d_rd", i), {16'h0, data_out}, {16'h0, vecs[i].exp_rd});
      chk($sformatf("v%0d_hit", i), {31'h0, hit}, {31'h0, vecs[i].exp_hit});
      tick();
      chk($sformatf("v%0d_out", i), gpio_out, vecs[i].exp_out);
      chk($sformatf("v%0d_oe", i), gpio_oe, vecs[i].exp_oe);
      chk($sformatf("v%0d_irq", i), {31'h0, irq}, 32'h0);
    end
    drive(1'b0, 1'b0, 15'h0, 16'h0);

    // Synchroniser latency on port 1 bit 0 (input direction).
    gpio_in = 32'h0001_0000;
    tick();
    check_rd("sync_in_1clk", 15'h6007, 16'h0000);
    tick();
    check_rd("sync_in_2clk", 15'h6007, 16'h0001);
    check_rd("sync_edge_2clk", 15'h6008, 16'h0000);
    tick();
    check_rd("sync_edge_3clk", 15'h6008, 16'h0001);
    chk("sync_irq_3clk", {31'h0, irq}, 32'h0);
    tick();
    chk("sync_irq_4clk", {31'h0, irq}, 32'h1);

    // Write-1-to-clear; irq follows one clock later.
    drive(1'b1, 1'b1, 15'h6008, 16'h0001);
    #1;
    chk("clr_rd_before", {16'h0, data_out}, 32'h0001);
    tick();
    check_rd("clr_edge", 15'h6008, 16'h0000);
    chk("clr_irq_same", {31'h0, irq}, 32'h1);
    tick();
    chk("clr_irq_next", {31'h0, irq}, 32'h0);

    // Set EDGE again, then clear in the same cycle as a fresh rising edge: set wins.
    gpio_in = 32'h0;
    repeat (3) tick();
    gpio_in = 32'h0001_0000;
    repeat (3) tick();
    check_rd("race_pre_edge", 15'h6008, 16'h0001);
    gpio_in = 32'h0;
    repeat (3) tick();
    gpio_in = 32'h0001_0000;
    repeat (2) tick();
    write_cycle(15'h6008, 16'h0001);
    check_rd("race_edge", 15'h6008, 16'h0001);
    chk("race_irq", {31'h0, irq}, 32'h1);
    tick();
    chk("race_irq_next", {31'h0, irq}, 32'h1);
    write_cycle(15'h6008, 16'h0001);
    check_rd("race_final_clr", 15'h6008, 16'h0000);
    tick();
    chk("race_final_irq", {31'h0, irq}, 32'h0);

    // Output-direction bits are read back on IN but never flag EDGE.
    gpio_in = 32'h0001_0008;
    repeat (3) tick();
    check_rd("mask_in", 15'h6003, 16'h0008);
    check_rd("mask_edge", 15'h6004, 16'h0000);
    tick();
    chk("mask_irq", {31'h0, irq}, 32'h0);

    // Switching bit 3 back to input while high does not set EDGE.
    write_cycle(15'h6002, 16'h00F7);
    chk("dir_oe", gpio_oe, 32'h00F0_00F7);
    repeat (3) tick();
    check_rd("dir_no_retro", 15'h6004, 16'h0000);
    chk("dir_no_irq", {31'h0, irq}, 32'h0);

    // Reset asserted across a write edge: the write is lost.
    drive(1'b1, 1'b1, 15'h6001, 16'h1111);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_async_out", gpio_out, 32'h0);
    chk("mid_rst_async_oe", gpio_oe, 32'h0);
    tick();
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 15'h0, 16'h0);
    tick();
    check_rd("mid_rst_out_rd", 15'h6001, 16'h0000);
    chk("mid_rst_gpio_out", gpio_out, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
